fp_alu_issuer: RTL and testbench

- Command-side master for fp_alu: accepts queued (operation, a, b) commands, drives the ALU's ce/operation/a/b inputs, and waits for rdy.
- Captures the result and returns it on a valid/ready response channel.
- Replaces bench-style poking of fp_alu with a synthesizable issuer, so a controller or CPU datapath can stream FP operations with backpressure.
- A watchdog recovers the ALU with a one-cycle sclr if rdy never arrives.

---
 rtl/fp_alu_pkg.sv | 24 ++
 rtl/fp_cmd_fifo.sv | 57 +++++
 rtl/fp_alu_issuer.sv | 154 +++++++++++++++
 tb/tb_fp_alu_issuer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_alu_pkg.sv
// Shared definitions for the fp_alu command issuer: opcode map, FSM states, QNAN.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fp_alu_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] FP_OP_NOP = 6'd0;
  localparam logic [OP_W-1:0] FP_OP_ADD = 6'd1;
  localparam logic [OP_W-1:0] FP_OP_SUB = 6'd2;
  localparam logic [OP_W-1:0] FP_OP_MUL = 6'd3;
  localparam logic [OP_W-1:0] FP_OP_DIV = 6'd4;

  // Result returned when the watchdog gives up on the ALU
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } issuer_state_t;

endpackage

// File: rtl/fp_cmd_fifo.sv
// Generic synchronous FIFO holding queued ALU commands; head entry is combinational.
// Latency: an entry pushed at edge N is visible at head (empty=0) after edge N.
// Backpressure: full is driven from the registered count; push while full / pop while empty are ignored.
module fp_cmd_fifo #(
  parameter int W     = 70,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         sclr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array; no reset needed since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); push+pop keeps count unchanged
  always_ff @(posedge clk) begin
    if (sclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fp_alu_issuer.sv
// Queues (op, a, b) commands, issues them one at a time to fp_alu and returns results.
// Latency: command push to alu_ce is 2 cycles; alu_rdy to rsp_valid is 1 cycle; watchdog fires after TIMEOUT cycles in WAIT.
// Backpressure: cmd_ready = FIFO not full (registered count); a held response stalls further issue until rsp_ready.
module fp_alu_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64,
  parameter int OP_W    = fp_alu_pkg::OP_W
) (
  input  logic            clk,
  input  logic            sclr,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OP_W-1:0] cmd_op,
  input  logic [31:0]     cmd_a,
  input  logic [31:0]     cmd_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_result,
  output logic            rsp_timeout,
  output logic            alu_ce,
  output logic            alu_sclr,
  output logic [OP_W-1:0] alu_operation,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  input  logic            alu_rdy,
  input  logic [31:0]     alu_result,
  output logic            busy
);

  import fp_alu_pkg::issuer_state_t;
  import fp_alu_pkg::ST_IDLE;
  import fp_alu_pkg::ST_ISSUE;
  import fp_alu_pkg::ST_WAIT;
  import fp_alu_pkg::ST_HOLD;
  import fp_alu_pkg::FP_QNAN;

  localparam int WD_W = $clog2(TIMEOUT);

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [31:0]     a;
    logic [31:0]     b;
  } cmd_t;

  cmd_t          cmd_in;
  cmd_t          cmd_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  issuer_state_t state;
  issuer_state_t state_nxt;
  logic [WD_W-1:0] wd;
  logic          wd_fire;
  logic          wd_fire_q;
  logic          rdy_hit;

  assign cmd_in    = '{op: cmd_op, a: cmd_a, b: cmd_b};
  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;

  // rdy is only honoured from WAIT; it beats the watchdog when both land together
  assign rdy_hit = (state == ST_WAIT) && alu_rdy;
  assign wd_fire = (state == ST_WAIT) && !alu_rdy && (wd == WD_W'(TIMEOUT - 1));

  fp_cmd_fifo #(
    .W     ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .sclr  (sclr),
    .push  (fifo_push),
    .din   (cmd_in),
    .pop   (fifo_pop),
    .head  (cmd_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (sclr) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state: one command in flight, response must drain before the next issue
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!fifo_empty)          state_nxt = ST_ISSUE;
      ST_ISSUE:                           state_nxt = ST_WAIT;
      ST_WAIT:  if (alu_rdy || wd_fire)   state_nxt = ST_HOLD;
      ST_HOLD:  if (rsp_ready)            state_nxt = ST_IDLE;
      default:                            state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: ALU enable, ALU reset (issuer reset or one-cycle watchdog pulse), busy
  always_comb begin
    alu_ce   = (state == ST_ISSUE) || (state == ST_WAIT);
    alu_sclr = sclr || wd_fire_q;
    busy     = (state != ST_IDLE) || !fifo_empty;
  end

  // Command register: operands latched on pop and held until the next pop
  always_ff @(posedge clk) begin
    if (sclr) begin
      alu_operation <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
    end else if (fifo_pop) begin
      alu_operation <= cmd_head.op;
      alu_a         <= cmd_head.a;
      alu_b         <= cmd_head.b;
    end
  end

  // Watchdog: cleared on issue, counts WAIT cycles without rdy; fire flag becomes the sclr pulse
  always_ff @(posedge clk) begin
    if (sclr) begin
      wd        <= '0;
      wd_fire_q <= 1'b0;
    end else begin
      wd_fire_q <= wd_fire;
      if (state == ST_ISSUE) begin
        wd <= '0;
      end else if ((state == ST_WAIT) && !alu_rdy && !wd_fire) begin
        wd <= wd + 1'b1;
      end
    end
  end

  // Response register: loaded from the ALU or the watchdog, held until rsp_ready
  always_ff @(posedge clk) begin
    if (sclr) begin
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_result  <= '0;
    end else if (rdy_hit) begin
      rsp_valid   <= 1'b1;
      rsp_timeout <= 1'b0;
      rsp_result  <= alu_result;
    end else if (wd_fire) begin
      rsp_valid   <= 1'b1;
      rsp_timeout <= 1'b1;
      rsp_result  <= FP_QNAN;
    end else if ((state == ST_HOLD) && rsp_ready) begin
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_alu_issuer.sv
// Scoreboard bench for fp_alu_issuer with a behavioural fp_alu of programmable latency.
// Latency: model asserts rdy in the lat-th consecutive ce cycle (lat=0 never answers).
// Backpressure: rsp_ready is fixed or randomised per test.
module tb_fp_alu_issuer;
  import fp_alu_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic            clk;
  logic            sclr;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [OP_W-1:0] cmd_op;
  logic [31:0]     cmd_a;
  logic [31:0]     cmd_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_result;
  logic            rsp_timeout;
  logic            alu_ce;
  logic            alu_sclr;
  logic [OP_W-1:0] alu_operation;
  logic [31:0]     alu_a;
  logic [31:0]     alu_b;
  logic            alu_rdy;
  logic [31:0]     alu_result;
  logic            busy;

  fp_alu_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .OP_W(OP_W)) dut (
    .clk           (clk),
    .sclr          (sclr),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_timeout   (rsp_timeout),
    .alu_ce        (alu_ce),
    .alu_sclr      (alu_sclr),
    .alu_operation (alu_operation),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_rdy       (alu_rdy),
    .alu_result    (alu_result),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   lat = 3;
  int   ce_run = 0;
  int   ce_cyc = 0;
  int   sclr_cyc = 0;
  int   last_ce = 0;
  int   last_sclr = 0;
  int   rsp_seen = 0;
  int   hold_err = 0;
  int   n, ce_at, rsp_base;
  bit   rr_mode = 1'b0;
  bit   rdy_fixed = 1'b1;

  logic            prev_ce = 1'b0;
  logic [OP_W-1:0] prev_op;
  logic [31:0]     prev_a, prev_b, prev_res;
  logic            prev_to;
  logic            prev_stall = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural ALU: deterministic result, exact 10+50 add, programmable rdy latency
  function automatic logic [31:0] alu_fn(input logic [OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == FP_OP_ADD && a == 32'h41200000 && b == 32'h42480000) return 32'h42700000;
    return a ^ {b[15:0], b[31:16]} ^ 32'(op);
  endfunction

  // rdy lands in ce cycle lat-1 counted from ISSUE; it is honoured only from WAIT within the watchdog window
  function automatic bit exp_timeout(input int l);
    return !(l >= 2 && l <= TIMEOUT + 1);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (alu_sclr || !alu_ce) ce_run <= 0;
    else                     ce_run <= ce_run + 1;
  end

  assign alu_rdy    = alu_ce && (lat != 0) && (ce_run == lat - 1);
  assign alu_result = alu_fn(alu_operation, alu_a, alu_b);

  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = rr_mode ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  // Monitor: per-transaction ce/sclr counts, stability of operands and stalled responses, scoreboard pops
  always @(negedge clk) begin
    exp_t e;
    if (sclr) begin
      ce_cyc   = 0;
      sclr_cyc = 0;
    end else begin
      if (alu_ce)   ce_cyc++;
      if (alu_sclr) sclr_cyc++;
    end
    if (alu_ce && prev_ce && (alu_a !== prev_a || alu_b !== prev_b || alu_operation !== prev_op)) hold_err++;
    if (prev_stall && (!rsp_valid || rsp_result !== prev_res || rsp_timeout !== prev_to)) hold_err++;
    prev_ce    = alu_ce;
    prev_a     = alu_a;
    prev_b     = alu_b;
    prev_op    = alu_operation;
    prev_res   = rsp_result;
    prev_to    = rsp_timeout;
    prev_stall = rsp_valid && !rsp_ready && !sclr;
    if (rsp_valid && rsp_ready && !sclr) begin
      rsp_seen++;
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_result", rsp_result, e.res);
        check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
      end
      last_ce   = ce_cyc;
      last_sclr = sclr_cyc;
      ce_cyc    = 0;
      sclr_cyc  = 0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic push(input logic [OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit   done = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    for (int k = 0; k < 500 && !done; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        e.to = exp_timeout(lat);
        e.res = e.to ? FP_QNAN : alu_fn(op, a, b);
        sb.push_back(e);
        acc_cyc = cyc;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (!done) check("push_accept", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 600) begin
      @(negedge clk);
      k++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1);
  end

  initial begin
    sclr = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_alu_sclr", 32'(alu_sclr), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_alu_ce", 32'(alu_ce), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    sclr = 1'b0;
    @(negedge clk);
    check("post_rst_alu_sclr", 32'(alu_sclr), 32'd0);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;

    // Single add, ALU latency 3
    lat = 3;
    push(FP_OP_ADD, 32'h41200000, 32'h42480000);
    n = 0;
    while (!alu_ce && n < 20) begin @(negedge clk); n++; end
    check("add_ce_delay", 32'(cyc - acc_cyc), 32'd2);
    ce_at = cyc;
    check("add_alu_op", 32'(alu_operation), 32'(FP_OP_ADD));
    check("add_alu_a", alu_a, 32'h41200000);
    check("add_alu_b", alu_b, 32'h42480000);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    check("add_rsp_delay", 32'(cyc - ce_at), 32'd3);
    check("add_result", rsp_result, 32'h42700000);
    check("add_timeout", 32'(rsp_timeout), 32'd0);
    drain();

    // Fill and backpressure: 1 in flight + 4 queued, response stalled
    rdy_fixed = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) push(FP_OP_MUL, 32'h3F800000 + 32'(i), 32'h40000000 + 32'(i * 7));
    @(negedge clk);
    check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    repeat (6) @(negedge clk);
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bp_head_result", rsp_result, sb[0].res);
    @(posedge clk); #1;
    rdy_fixed = 1'b1;
    push(FP_OP_SUB, 32'hDEADBEEF, 32'h12345678);
    drain();

    // Streaming with random rsp_ready: concurrent push/pop and pointer wrap
    rr_mode = 1'b1;
    lat = 2;
    for (int i = 0; i < 12; i++) push(OP_W'(i % 5), $urandom, $urandom);
    drain();
    rr_mode = 1'b0;
    @(posedge clk); #1;

    // Watchdog timeout, then a normal command
    lat = 0;
    push(FP_OP_DIV, 32'h3F800000, 32'h00000000);
    drain();
    check("to_ce_cycles", 32'(last_ce), 32'(TIMEOUT + 1));
    check("to_sclr_pulse", 32'(last_sclr), 32'd1);
    lat = 3;
    push(FP_OP_ADD, 32'h11111111, 32'h22222222);
    drain();
    check("after_to_ce_cycles", 32'(last_ce), 32'd3);
    check("after_to_sclr", 32'(last_sclr), 32'd0);

    // rdy on the same cycle the watchdog would fire: rdy wins
    lat = TIMEOUT + 1;
    push(FP_OP_SUB, 32'hCAFEF00D, 32'h0BADF00D);
    drain();
    check("edge_ce_cycles", 32'(last_ce), 32'(TIMEOUT + 1));
    check("edge_sclr", 32'(last_sclr), 32'd0);

    // rdy only during ISSUE is ignored, so the watchdog fires
    lat = 1;
    push(FP_OP_MUL, 32'h40400000, 32'h40800000);
    drain();
    check("issue_rdy_sclr", 32'(last_sclr), 32'd1);

    // Reset mid-WAIT with two commands queued: everything discarded
    lat = 0;
    for (int i = 0; i < 3; i++) push(FP_OP_ADD, 32'(i), 32'(i + 100));
    repeat (3) @(negedge clk);
    check("mid_wait_alu_ce", 32'(alu_ce), 32'd1);
    rsp_base = rsp_seen;
    @(posedge clk); #1;
    sclr = 1'b1;
    @(negedge clk);
    check("mid_rst_alu_sclr", 32'(alu_sclr), 32'd1);
    @(posedge clk); #1;
    sclr = 1'b0;
    sb.delete();
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_alu_ce", 32'(alu_ce), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (3 * TIMEOUT) @(negedge clk);
    check("mid_rst_no_rsp", 32'(rsp_seen - rsp_base), 32'd0);

    check("hold_stability", 32'(hold_err), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
